// File: rtl/dsp_mac_sequencer.sv
// MAC stream controller for one DSP48A1 slice.
// Issues OPMODE sequences, tracks terms through the slice and buffers frame sums.
module dsp_mac_sequencer #(
    parameter int RES_DEPTH = 4,
    parameter int MAC_LAT   = 3,
    parameter int OP_SKEW   = 1,
    parameter int RST_HOLD  = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [17:0] IN_A,
    input  logic [17:0] IN_B,
    input  logic        IN_LAST,
    output logic [17:0] DSP_A,
    output logic [17:0] DSP_B,
    output logic [7:0]  DSP_OPMODE,
    output logic        DSP_CE,
    output logic        DSP_RST,
    input  logic [47:0] DSP_P,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [47:0] OUT_DATA,
    output logic        BUSY
);

    localparam int AW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int HW = $clog2(RST_HOLD + 2);

    localparam logic [CW-1:0] DEPTH_C = CW'(RES_DEPTH);
    localparam logic [HW-1:0] HOLD_C  = HW'(RST_HOLD);

    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_HOLD  = 8'h08;

    logic          dsp_rst;
    logic [HW-1:0] hold_cnt;

    logic          accept;
    logic          in_frame;
    logic [CW-1:0] pending;

    logic [17:0]   dsp_a;
    logic [17:0]   dsp_b;
    logic [7:0]    opmode;

    logic [MAC_LAT:0] tag_v;
    logic [MAC_LAT:0] tag_l;
    logic [OP_SKEW:0] tag_f;

    logic [47:0]   mem [RES_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fill;
    logic          push;
    logic          pop;
    logic          out_valid;

    // Slice reset is stretched past RST_N release so its registers settle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dsp_rst  <= 1'b1;
            hold_cnt <= '0;
        end else if (dsp_rst) begin
            if (hold_cnt == HOLD_C) begin
                dsp_rst <= 1'b0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    assign IN_READY = !dsp_rst && (pending < DEPTH_C);
    assign accept   = IN_VALID && IN_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dsp_a    <= '0;
            dsp_b    <= '0;
            in_frame <= 1'b0;
        end else begin
            dsp_a <= accept ? IN_A : 18'd0;
            dsp_b <= accept ? IN_B : 18'd0;
            if (accept) begin
                in_frame <= !IN_LAST;
            end
        end
    end

    // Index k of each tag vector describes the term issued k cycles ago.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tag_v <= '0;
            tag_l <= '0;
            tag_f <= '0;
        end else begin
            tag_v[0] <= accept;
            tag_l[0] <= accept && IN_LAST;
            tag_f[0] <= accept && !in_frame;
            for (int i = 1; i <= MAC_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
            for (int i = 1; i <= OP_SKEW; i++) begin
                tag_f[i] <= tag_f[i-1];
            end
        end
    end

    always_comb begin
        opmode = OPM_HOLD;
        unique case (1'b1)
            tag_v[OP_SKEW] && tag_f[OP_SKEW]:  opmode = OPM_FIRST;
            tag_v[OP_SKEW] && !tag_f[OP_SKEW]: opmode = OPM_ACC;
            default: ;
        endcase
    end

    assign push = tag_v[MAC_LAT] && tag_l[MAC_LAT];
    assign pop  = out_valid && OUT_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending <= '0;
        end else begin
            unique case ({accept && IN_LAST, pop})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: ;
            endcase
        end
    end

    // Credit accounting keeps pushes away from a full buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= DSP_P;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: ;
            endcase
        end
    end

    assign out_valid  = (fill != '0);

    assign DSP_A      = dsp_a;
    assign DSP_B      = dsp_b;
    assign DSP_OPMODE = opmode;
    assign DSP_RST    = dsp_rst;
    assign DSP_CE     = !dsp_rst;
    assign OUT_VALID  = out_valid;
    assign OUT_DATA   = mem[rd_ptr];
    assign BUSY       = (|tag_v) || out_valid || in_frame;

endmodule
